// File: rtl/nexys_starship_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_pkg
// Shared definitions for the Nexys Starship hazard scheduler:
//   - one-hot FSM state encodings
//   - LFSR feedback mask and default seed
//   - small combinational helpers (LFSR step, gap computation, free-channel
//     scan, saturating increment)
// -----------------------------------------------------------------------------
package nexys_starship_pkg;

  typedef logic [3:0] hz_state_t;

  localparam hz_state_t ST_IDLE = 4'b0001;
  localparam hz_state_t ST_WAIT = 4'b0010;
  localparam hz_state_t ST_FIRE = 4'b0100;
  localparam hz_state_t ST_HOLD = 4'b1000;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Result of the free-channel scan. Sized for the largest supported
  // channel count (8) so the helper is independent of NUM_CH.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } scan_t;

  // One step of the 16-bit Galois LFSR (right shift, feed back on bit 0).
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Inter-hazard gap: base scaled down by level plus 0..7 ticks of jitter,
  // computed modulo 256 and never allowed to be zero.
  function automatic logic [7:0] gap_calc(input logic [7:0] base,
                                          input logic [1:0] lvl,
                                          input logic [2:0] jitter);
    logic [7:0] g;
    g = (base >> lvl) + {5'b00000, jitter};
    return (g == 8'd0) ? 8'd1 : g;
  endfunction

  // First non-busy channel, scanning upward from start and wrapping at
  // num_ch (a power of two, so wrap is a mask).
  function automatic scan_t find_free(input logic [7:0] busy,
                                      input logic [2:0] start,
                                      input int         num_ch);
    scan_t      r;
    logic [2:0] mask;
    logic [2:0] c;
    logic       hit;
    mask    = 3'(num_ch - 1);
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      c       = (start + 3'(i)) & mask;
      hit     = (i < num_ch) && !r.found && !busy[c];
      r.idx   = hit ? c : r.idx;
      r.found = r.found | hit;
    end
    return r;
  endfunction

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// -----------------------------------------------------------------------------
// nexys_starship_lfsr16
// Free-running 16-bit Galois LFSR (mask 16'hB400), advancing every clock.
// Ports:
//   Clk     in   system clock
//   Reset   in   asynchronous active-high reset, loads SEED
//   lfsr_o  out  current LFSR value (registered)
// SEED must be nonzero; a nonzero state never maps to zero.
// -----------------------------------------------------------------------------
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// -----------------------------------------------------------------------------
// nexys_starship_hazard_gen
// Central hazard scheduler. Paces break requests on timer_tick, picks a
// channel that is neither broken nor shielded, and holds a one-hot request
// until the repair SM reports broken, the channel becomes shielded, or the
// hold window expires.
// Ports:
//   Clk            in   system clock
//   Reset          in   asynchronous active-high reset
//   play_flag      in   game running; leaves IDLE
//   gameover_ctrl  in   game over; forces IDLE (highest priority)
//   timer_tick     in   single-cycle pacing strobe
//   level          in   difficulty 0..3 (shortens the gap)
//   broken         in   per-channel broken flag from repair SMs
//   shield         in   per-channel shield active
//   ch_random      out  one-hot break request (registered)
//   random_hex     out  combo value for the requested channel (registered)
//   q_Idle..q_Hold out  one-hot state outputs
//   hazard_count   out  successful breaks this game, saturating at 255
// -----------------------------------------------------------------------------
module nexys_starship_hazard_gen
  import nexys_starship_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter logic [15:0] SEED        = DEFAULT_SEED,
  parameter int          BASE_GAP    = 8,
  parameter int          HOLD_CYCLES = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              play_flag,
  input  logic              gameover_ctrl,
  input  logic              timer_tick,
  input  logic [1:0]        level,
  input  logic [NUM_CH-1:0] broken,
  input  logic [NUM_CH-1:0] shield,
  output logic [NUM_CH-1:0] ch_random,
  output logic [3:0]        random_hex,
  output logic              q_Idle,
  output logic              q_Wait,
  output logic              q_Fire,
  output logic              q_Hold,
  output logic [7:0]        hazard_count
);

  localparam logic [7:0] BASE_GAP_B = 8'(BASE_GAP);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] CH_MASK    = 3'(NUM_CH - 1);

  // Registered state and datapath
  hz_state_t         state_q, state_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic [NUM_CH-1:0] ch_random_q, ch_random_d;
  logic [3:0]        random_hex_q, random_hex_d;
  logic [7:0]        hazard_count_q, hazard_count_d;

  // Combinational helpers
  logic [15:0]       lfsr_s;
  logic [7:0]        broken_x_s;
  logic [7:0]        shield_x_s;
  logic [7:0]        busy_s;
  logic [2:0]        start_s;
  scan_t             scan_s;
  logic [7:0]        gap_load_s;
  logic [NUM_CH-1:0] ch_onehot_s;
  logic              lfsr_unused_s;

  nexys_starship_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk    (Clk),
    .Reset  (Reset),
    .lfsr_o (lfsr_s)
  );

  // Only the start, jitter and combo fields of the LFSR are consumed.
  assign lfsr_unused_s = ^{lfsr_s[15:12], lfsr_s[7], lfsr_s[3]};

  // Channel scan, gap value and candidate one-hot request.
  // broken/shield are widened to 8 bits so a 3-bit channel index can
  // address them for any legal NUM_CH.
  always_comb begin
    broken_x_s                = 8'd0;
    shield_x_s                = 8'd0;
    broken_x_s[NUM_CH-1:0]    = broken;
    shield_x_s[NUM_CH-1:0]    = shield;
    busy_s                    = broken_x_s | shield_x_s;
    start_s                   = lfsr_s[2:0] & CH_MASK;
    scan_s                    = find_free(busy_s, start_s, NUM_CH);
    gap_load_s                = gap_calc(BASE_GAP_B, level, lfsr_s[6:4]);
    for (int k = 0; k < NUM_CH; k++) begin
      ch_onehot_s[k] = (scan_s.idx == 3'(k));
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      gap_cnt_q      <= 8'd0;
      hold_cnt_q     <= 8'd0;
      sel_q          <= 3'd0;
      ch_random_q    <= '0;
      random_hex_q   <= 4'd0;
      hazard_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      sel_q          <= sel_d;
      ch_random_q    <= ch_random_d;
      random_hex_q   <= random_hex_d;
      hazard_count_q <= hazard_count_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    sel_d          = sel_q;
    ch_random_d    = ch_random_q;
    random_hex_d   = random_hex_q;
    hazard_count_d = hazard_count_q;

    case (state_q)
      ST_IDLE: begin
        ch_random_d = '0;
        // A simultaneous game-over keeps the scheduler parked.
        if (play_flag && !gameover_ctrl) begin
          state_d        = ST_WAIT;
          hazard_count_d = 8'd0;
          gap_cnt_d      = gap_load_s;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (gameover_ctrl) begin
          state_d     = ST_IDLE;
          ch_random_d = '0;
        end else if (timer_tick) begin
          if (gap_cnt_q <= 8'd1) begin
            state_d = ST_FIRE;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_FIRE: begin
        if (gameover_ctrl) begin
          state_d     = ST_IDLE;
          ch_random_d = '0;
        end else if (scan_s.found) begin
          state_d      = ST_HOLD;
          sel_d        = scan_s.idx;
          ch_random_d  = ch_onehot_s;
          random_hex_d = lfsr_s[11:8];
          hold_cnt_d   = 8'd0;
        end else begin
          // Every channel busy: retry on the very next tick.
          state_d     = ST_WAIT;
          ch_random_d = '0;
          gap_cnt_d   = 8'd1;
        end
      end

      ST_HOLD: begin
        if (gameover_ctrl) begin
          // Frozen count even if broken rises in this same cycle.
          state_d     = ST_IDLE;
          ch_random_d = '0;
        end else if (broken_x_s[sel_q]) begin
          state_d        = ST_WAIT;
          ch_random_d    = '0;
          hazard_count_d = sat_inc8(hazard_count_q);
          gap_cnt_d      = gap_load_s;
        end else if (shield_x_s[sel_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d     = ST_WAIT;
          ch_random_d = '0;
          gap_cnt_d   = gap_load_s;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        ch_random_d = '0;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    q_Idle       = (state_q == ST_IDLE);
    q_Wait       = (state_q == ST_WAIT);
    q_Fire       = (state_q == ST_FIRE);
    q_Hold       = (state_q == ST_HOLD);
    ch_random    = ch_random_q;
    random_hex   = random_hex_q;
    hazard_count = hazard_count_q;
  end

endmodule

// File: tb/tb_nexys_starship_hazard_gen.sv
// -----------------------------------------------------------------------------
// Testbench for nexys_starship_hazard_gen: a hand-computed vector table for
// the opening game, directed corner sequences, then random play checked
// cycle by cycle against a behavioural model of the scheduler rules.
// -----------------------------------------------------------------------------
module tb_nexys_starship_hazard_gen;

  localparam int          NUM_CH      = 4;
  localparam int          BASE_GAP    = 8;
  localparam int          HOLD_CYCLES = 8;
  localparam logic [15:0] SEED        = 16'hACE1;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_FIRE = 2;
  localparam int P_HOLD = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        play_flag = 1'b0;
  logic        gameover_ctrl = 1'b0;
  logic        timer_tick = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [3:0]  broken = 4'd0;
  logic [3:0]  shield = 4'd0;
  logic [3:0]  ch_random;
  logic [3:0]  random_hex;
  logic        q_Idle, q_Wait, q_Fire, q_Hold;
  logic [7:0]  hazard_count;

  int n_pass  = 0;
  int n_total = 0;

  nexys_starship_hazard_gen #(
    .NUM_CH      (NUM_CH),
    .SEED        (SEED),
    .BASE_GAP    (BASE_GAP),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .timer_tick    (timer_tick),
    .level         (level),
    .broken        (broken),
    .shield        (shield),
    .ch_random     (ch_random),
    .random_hex    (random_hex),
    .q_Idle        (q_Idle),
    .q_Wait        (q_Wait),
    .q_Fire        (q_Fire),
    .q_Hold        (q_Hold),
    .hazard_count  (hazard_count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit [15:0] m_lfsr;
  int        m_phase, m_gap, m_held, m_chan, m_hex, m_count;

  function automatic int gap_of(input bit [15:0] l, input int lv);
    int g;
    g = ((BASE_GAP >> lv) + ((int'(l) >> 4) & 7)) % 256;
    if (g == 0) g = 1;
    return g;
  endfunction

  task automatic model_reset();
    m_lfsr  = SEED;
    m_phase = P_IDLE;
    m_gap   = 0;
    m_held  = 0;
    m_chan  = -1;
    m_hex   = 0;
    m_count = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit [15:0] nxt;
    int        pick, c;
    nxt = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    case (m_phase)
      P_IDLE: begin
        m_chan = -1;
        if (play_flag && !gameover_ctrl) begin
          m_phase = P_WAIT;
          m_count = 0;
          m_gap   = gap_of(m_lfsr, int'(level));
        end
      end
      P_WAIT: begin
        if (gameover_ctrl) m_phase = P_IDLE;
        else if (timer_tick) begin
          if (m_gap <= 1) m_phase = P_FIRE;
          else m_gap = m_gap - 1;
        end
      end
      P_FIRE: begin
        if (gameover_ctrl) begin
          m_phase = P_IDLE;
          m_chan  = -1;
        end else begin
          pick = -1;
          for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(m_lfsr) % NUM_CH + k) % NUM_CH;
            if (pick < 0 && !broken[c] && !shield[c]) pick = c;
          end
          if (pick >= 0) begin
            m_chan  = pick;
            m_hex   = (int'(m_lfsr) >> 8) & 15;
            m_held  = 0;
            m_phase = P_HOLD;
          end else begin
            m_gap   = 1;
            m_phase = P_WAIT;
          end
        end
      end
      default: begin // P_HOLD
        if (gameover_ctrl) begin
          m_phase = P_IDLE;
          m_chan  = -1;
        end else if (broken[m_chan]) begin
          m_chan  = -1;
          if (m_count < 255) m_count = m_count + 1;
          m_gap   = gap_of(m_lfsr, int'(level));
          m_phase = P_WAIT;
        end else begin
          m_held = m_held + 1;
          if (shield[m_chan] || m_held == HOLD_CYCLES) begin
            m_chan  = -1;
            m_gap   = gap_of(m_lfsr, int'(level));
            m_phase = P_WAIT;
          end
        end
      end
    endcase
    m_lfsr = nxt;
  endtask

  task automatic compare_model();
    int es, ec;
    es = 1 << m_phase;
    ec = (m_chan >= 0) ? (1 << m_chan) : 0;
    chk("model.state", 32'({q_Hold, q_Fire, q_Wait, q_Idle}), 32'(es));
    chk("model.ch_random", 32'(ch_random), 32'(ec));
    chk("model.random_hex", 32'(random_hex), 32'(m_hex));
    chk("model.hazard_count", 32'(hazard_count), 32'(m_count));
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    compare_model();
  endtask

  task automatic goto_hold(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (q_Hold) ok = 1'b1;
    end
    chk({tag, ".reach_hold"}, 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       play, gover, tick;
    logic [1:0] lvl;
    logic [3:0] brk, shd;
    logic [3:0] e_state, e_ch, e_hex;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(input logic p, input logic g, input logic t, input logic [1:0] l,
                               input logic [3:0] b, input logic [3:0] s, input logic [3:0] es,
                               input logic [3:0] ec, input logic [3:0] eh, input logic [7:0] en);
    vec_t v;
    v.play = p; v.gover = g; v.tick = t; v.lvl = l; v.brk = b; v.shd = s;
    v.e_state = es; v.e_ch = ec; v.e_hex = eh; v.e_cnt = en;
    return v;
  endfunction

  initial begin
    bit ok;
    int n, guard, fires, chhigh, k, saved;

    // Opening game from SEED. LFSR per edge: ACE1 E270 7138 389C 1C4E 0E27
    // B313 ED89 C2C4 6162 30B1 AC58. Play at E270, level 3: gap 1+7 = 8.
    // FIRE sees AC58: start ch0, ch0 broken, ch1 shielded -> ch2, hex C.
    tbl[0]  = mkv(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, 8'd0);
    tbl[1]  = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'd0);
    for (int i = 2; i <= 8; i++)
      tbl[i] = mkv(1'b1, 1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'd0);
    tbl[9]  = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 8'd0);
    tbl[10] = mkv(1'b1, 1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0100, 4'h0, 4'h0, 8'd0);
    tbl[11] = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h1, 4'h2, 4'b1000, 4'h4, 4'hC, 8'd0);
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b1000, 4'h4, 4'hC, 8'd0);
    tbl[13] = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b1000, 4'h4, 4'hC, 8'd0);
    tbl[14] = mkv(1'b1, 1'b0, 1'b0, 2'd3, 4'h4, 4'h0, 4'b0010, 4'h0, 4'hC, 8'd1);
    tbl[15] = mkv(1'b1, 1'b1, 1'b0, 2'd3, 4'h0, 4'h0, 4'b0001, 4'h0, 4'hC, 8'd1);
    tbl[16] = mkv(1'b0, 1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b0001, 4'h0, 4'hC, 8'd1);

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("reset.state", 32'({q_Hold, q_Fire, q_Wait, q_Idle}), 32'h1);
    chk("reset.ch_random", 32'(ch_random), 32'h0);
    chk("reset.random_hex", 32'(random_hex), 32'h0);
    chk("reset.hazard_count", 32'(hazard_count), 32'h0);
    chk("reset.lfsr", 32'(dut.u_lfsr.lfsr_o), 32'hACE1);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      play_flag = tbl[i].play; gameover_ctrl = tbl[i].gover; timer_tick = tbl[i].tick;
      level = tbl[i].lvl; broken = tbl[i].brk; shield = tbl[i].shd;
      @(posedge Clk);
      #1;
      chk($sformatf("row%0d.state", i), 32'({q_Hold, q_Fire, q_Wait, q_Idle}), 32'(tbl[i].e_state));
      chk($sformatf("row%0d.ch_random", i), 32'(ch_random), 32'(tbl[i].e_ch));
      chk($sformatf("row%0d.random_hex", i), 32'(random_hex), 32'(tbl[i].e_hex));
      chk($sformatf("row%0d.hazard_count", i), 32'(hazard_count), 32'(tbl[i].e_cnt));
      if (i == 0) chk("lfsr_after_1clk", 32'(dut.u_lfsr.lfsr_o), 32'hE270);
      if (i == 1) chk("gap_load", 32'(dut.gap_cnt_q), 32'd8);
    end

    // Re-synchronise DUT and model
    play_flag = 1'b0; gameover_ctrl = 1'b0; timer_tick = 1'b0; broken = 4'h0; shield = 4'h0;
    Reset = 1'b1;
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;

    // Every channel broken: never a request, FIRE and WAIT alternate
    broken = 4'hF; level = 2'd0; play_flag = 1'b1; timer_tick = 1'b1;
    fires = 0; chhigh = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (q_Fire) fires++;
      if (ch_random != 4'h0) chhigh++;
    end
    chk("allbroken.ch_high_cycles", 32'(chhigh), 32'd0);
    chk("allbroken.fire_ge_490", 32'(fires >= 490), 32'd1);
    gameover_ctrl = 1'b1;
    step();
    gameover_ctrl = 1'b0; broken = 4'h0;

    // Hold window expiry: request high for exactly HOLD_CYCLES cycles
    goto_hold("timeout", ok);
    saved = m_count;
    n = (ch_random != 4'h0) ? 1 : 0;
    guard = 0;
    while (ch_random != 4'h0 && guard < 32) begin
      step();
      if (ch_random != 4'h0) n++;
      guard++;
    end
    chk("timeout.high_cycles", 32'(n), 32'(HOLD_CYCLES));
    chk("timeout.count_same", 32'(hazard_count), 32'(saved));

    // Shield raised on the third held cycle
    goto_hold("shield", ok);
    k = (m_chan >= 0) ? m_chan : 0;
    n = (ch_random != 4'h0) ? 1 : 0;
    guard = 0;
    while (ch_random != 4'h0 && guard < 32) begin
      if (n == 3) shield = 4'b0001 << k;
      step();
      if (ch_random != 4'h0) n++;
      guard++;
    end
    shield = 4'h0;
    chk("shield.high_cycles", 32'(n), 32'd3);

    // Broken on the selected channel credits one hazard
    goto_hold("credit", ok);
    k = (m_chan >= 0) ? m_chan : 0;
    saved = m_count;
    step();
    broken = 4'b0001 << k;
    step();
    broken = 4'h0;
    chk("credit.ch_low", 32'(ch_random), 32'd0);
    chk("credit.wait", 32'(q_Wait), 32'd1);
    chk("credit.count_inc", 32'(hazard_count), 32'(saved + 1));

    // Game over together with broken: IDLE, count frozen
    goto_hold("gobrk", ok);
    k = (m_chan >= 0) ? m_chan : 0;
    saved = int'(hazard_count);
    gameover_ctrl = 1'b1;
    broken = 4'b0001 << k;
    step();
    chk("gobrk.idle", 32'(q_Idle), 32'd1);
    chk("gobrk.ch_low", 32'(ch_random), 32'd0);
    chk("gobrk.count_frozen", 32'(hazard_count), 32'(saved));
    gameover_ctrl = 1'b0; broken = 4'h0;

    // Async reset mid-HOLD, checked before any further clock edge
    goto_hold("areset", ok);
    #2;
    Reset = 1'b1;
    #1;
    chk("areset.state", 32'({q_Hold, q_Fire, q_Wait, q_Idle}), 32'h1);
    chk("areset.ch_random", 32'(ch_random), 32'h0);
    chk("areset.random_hex", 32'(random_hex), 32'h0);
    chk("areset.hazard_count", 32'(hazard_count), 32'h0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      play_flag     = ($urandom_range(0, 3) != 0);
      gameover_ctrl = ($urandom_range(0, 79) == 0);
      timer_tick    = ($urandom_range(0, 2) == 0);
      level         = 2'($urandom_range(0, 3));
      broken        = 4'($urandom) & 4'($urandom) & 4'($urandom);
      shield        = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
